// File: rtl/conv_encoder_param.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready handshakes,
// frame delimiting and optional zero-tail termination.
module conv_encoder_param #(
    parameter int           K       = 3,
    parameter logic [K-1:0] G0      = 3'b111,
    parameter logic [K-1:0] G1      = 3'b101,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_sym,
    output logic       out_last,
    output logic       busy
);

    if (K < 3 || K > 9) begin : g_bad_k
        $error("conv_encoder_param: K must be in 3..9");
    end

    typedef enum logic {DATA, TAIL} state_t;

    state_t       state;
    logic [K-2:0] sr;
    logic [3:0]   tail_cnt;

    logic         can_step;
    logic         u;
    logic         step;
    logic [K-1:0] w;

    // The single output register can take a new symbol when empty or being drained.
    assign can_step = !out_valid || out_ready;
    assign in_ready = (state == DATA) && can_step;
    assign u        = (state == DATA) ? in_bit : 1'b0;
    assign step     = (state == DATA) ? (in_valid && can_step) : can_step;
    assign w        = {u, sr};
    assign busy     = (state == TAIL) || out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DATA;
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_sym   <= 2'b00;
            out_last  <= 1'b0;
        end else if (step) begin
            out_valid <= 1'b1;
            out_sym   <= {^(w & G0), ^(w & G1)};
            sr        <= {u, sr[K-2:1]};
            out_last  <= 1'b0;
            if (state == DATA) begin
                if (in_last) begin
                    if (TAIL_EN) begin
                        state    <= TAIL;
                        tail_cnt <= 4'(K - 1);
                    end else begin
                        // Without a tail the next frame must still start from a clean register.
                        out_last <= 1'b1;
                        sr       <= '0;
                    end
                end
            end else begin
                tail_cnt <= tail_cnt - 4'd1;
                if (tail_cnt == 4'd1) begin
                    out_last <= 1'b1;
                    state    <= DATA;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Directed and randomised checks for conv_encoder_param in three configurations:
// baseline K=3, K=3 without tail, and K=7 (171/133 octal).
module tb_conv_encoder_param;

    localparam logic [6:0] G0_7 = 7'o171;
    localparam logic [6:0] G1_7 = 7'o133;

    typedef struct packed {
        logic        last;
        logic [1:0]  sym;
        int unsigned cyc;
    } mon_t;

    typedef struct packed {
        logic       v;
        logic       r;
        logic       ir;
        logic       last;
        logic [1:0] sym;
    } lg_t;

    typedef struct packed {
        logic [3:0] tst;
        logic       vin;
        logic       bin;
        logic       lin;
        logic [1:0] sym;
        logic       olast;
    } row_t;

    logic       clk;
    logic       rst       [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       in_bit    [3];
    logic       in_last   [3];
    logic       out_valid [3];
    logic       out_ready [3];
    logic [1:0] out_sym   [3];
    logic       out_last  [3];
    logic       busy      [3];
    logic [1:0] rmode     [3];
    logic       log_en;

    mon_t q0[$], q1[$], q2[$];
    lg_t  s_log[$];
    int unsigned cyc;
    logic [1:0]  tcnt;

    int errors;
    int checks;

    conv_encoder_param u_base (
        .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_bit(in_bit[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sym(out_sym[0]), .out_last(out_last[0]), .busy(busy[0])
    );

    conv_encoder_param #(.TAIL_EN(1'b0)) u_notail (
        .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_bit(in_bit[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sym(out_sym[1]), .out_last(out_last[1]), .busy(busy[1])
    );

    conv_encoder_param #(.K(7), .G0(G0_7), .G1(G1_7)) u_k7 (
        .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_bit(in_bit[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sym(out_sym[2]), .out_last(out_last[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: 0 low, 1 high, 2 pattern 1,0,0,1, 3 random (75% high).
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            case (rmode[d])
                2'd0:    out_ready[d] = 1'b0;
                2'd1:    out_ready[d] = 1'b1;
                2'd2:    out_ready[d] = (tcnt == 2'd0) || (tcnt == 2'd3);
                default: out_ready[d] = ($urandom_range(3) != 0);
            endcase
        end
        tcnt = tcnt + 2'd1;
    end

    // Record every consumed symbol; the transfer happens on the following rising edge.
    always @(negedge clk) begin
        cyc++;
        if (out_valid[0] && out_ready[0]) q0.push_back('{last: out_last[0], sym: out_sym[0], cyc: cyc});
        if (out_valid[1] && out_ready[1]) q1.push_back('{last: out_last[1], sym: out_sym[1], cyc: cyc});
        if (out_valid[2] && out_ready[2]) q2.push_back('{last: out_last[2], sym: out_sym[2], cyc: cyc});
        if (log_en)
            s_log.push_back('{v: out_valid[0], r: out_ready[0], ir: in_ready[0],
                              last: out_last[0], sym: out_sym[0]});
    end

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic mon_t qget(int d, int i);
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic send_bit(int d, logic b, logic l);
        int n;
        in_valid[d] = 1'b1;
        in_bit[d]   = b;
        in_last[d]  = l;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready[d]) break;
            n++;
            if (n > 1000) begin
                fail_timeout("send_bit");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int d, int n, int limit);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            #1;
            k++;
        end while (!(qsize(d) >= n && !busy[d]) && k < limit);
        if (!(qsize(d) >= n && !busy[d])) fail_timeout($sformatf("wait_done_dut%0d", d));
        @(posedge clk);
        #1;
    endtask

    row_t vecs[20];

    task automatic run_table(int t, int d);
        int base, n, k;
        base = qsize(d);
        n = 0;
        for (int r = 0; r < 20; r++) begin
            if (int'(vecs[r].tst) == t) begin
                if (vecs[r].vin) send_bit(d, vecs[r].bin, vecs[r].lin);
                n++;
            end
        end
        in_valid[d] = 1'b0;
        wait_done(d, base + n, 300);
        k = 0;
        for (int r = 0; r < 20; r++) begin
            if (int'(vecs[r].tst) == t && base + k < qsize(d)) begin
                mon_t m;
                m = qget(d, base + k);
                $display("t%0d dut%0d sym%0d: out_sym=%b out_last=%b (exp %b/%b)",
                         t, d, k, m.sym, m.last, vecs[r].sym, vecs[r].olast);
                check($sformatf("t%0d_sym%0d", t, k), 32'({m.last, m.sym}),
                      32'({vecs[r].olast, vecs[r].sym}));
                k++;
            end
        end
        check($sformatf("t%0d_count", t), 32'(qsize(d) - base), 32'(n));
    endtask

    initial begin
        int   base, b6, lasts, idx, bad, len, first_bad;
        logic xb[$];
        logic [2:0] exp2[$];
        int   flen[$];
        logic pg0, pg1;

        errors = 0;
        checks = 0;
        log_en = 1'b0;
        tcnt   = 2'd0;
        for (int d = 0; d < 3; d++) begin
            rst[d]      = 1'b1;
            in_valid[d] = 1'b0;
            in_bit[d]   = 1'b0;
            in_last[d]  = 1'b0;
            rmode[d]    = 2'd1;
        end

        //        tst   vin   bin   lin   sym    olast
        vecs[0]  = '{4'd1, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        vecs[1]  = '{4'd1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[2]  = '{4'd1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{4'd1, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0};
        vecs[4]  = '{4'd1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[5]  = '{4'd1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[6]  = '{4'd3, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0};
        vecs[7]  = '{4'd3, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0};
        vecs[8]  = '{4'd3, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};
        vecs[9]  = '{4'd4, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        vecs[10] = '{4'd4, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1};
        vecs[11] = '{4'd4, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1};
        vecs[12] = '{4'd6, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        vecs[13] = '{4'd6, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0};
        vecs[14] = '{4'd6, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
        vecs[15] = '{4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
        vecs[16] = '{4'd6, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0};
        vecs[17] = '{4'd6, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0};
        vecs[18] = '{4'd6, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0};
        vecs[19] = '{4'd6, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_out_valid%0d", d), 32'(out_valid[d]), 32'd0);
            check($sformatf("rst_out_sym%0d", d),   32'(out_sym[d]),   32'd0);
            check($sformatf("rst_out_last%0d", d),  32'(out_last[d]),  32'd0);
            check($sformatf("rst_busy%0d", d),      32'(busy[d]),      32'd0);
            check($sformatf("rst_in_ready%0d", d),  32'(in_ready[d]),  32'd1);
        end
        @(posedge clk);
        #1;

        // T1: baseline frame with a free-running sink.
        run_table(1, 0);

        // T2: same frame against a stalling sink; the symbol must hold while stalled.
        rmode[0] = 2'd2;
        log_en   = 1'b1;
        run_table(1, 0);
        log_en   = 1'b0;
        rmode[0] = 2'd1;
        for (int i = 1; i < s_log.size(); i++) begin
            if (s_log[i-1].v && !s_log[i-1].r) begin
                check($sformatf("t2_in_ready_stall%0d", i), 32'(s_log[i-1].ir), 32'd0);
                check($sformatf("t2_hold%0d", i), 32'({s_log[i].v, s_log[i].last, s_log[i].sym}),
                      32'({1'b1, s_log[i-1].last, s_log[i-1].sym}));
            end
        end

        // T3: reset in the middle of the tail, then a single-bit frame.
        base = qsize(0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b0, 1'b0);
        send_bit(0, 1'b1, 1'b0);
        send_bit(0, 1'b1, 1'b1);
        in_valid[0] = 1'b0;
        idx = 0;
        while (qsize(0) < base + 5 && idx < 100) begin
            @(negedge clk);
            #1;
            idx++;
        end
        if (qsize(0) < base + 5) fail_timeout("t3_wait5");
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        #1;
        check("t3_rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("t3_rst_out_last",  32'(out_last[0]),  32'd0);
        check("t3_rst_busy",      32'(busy[0]),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        check("t3_no_sixth", 32'(qsize(0) - base), 32'd5);
        run_table(3, 0);

        // T4: no tail; second frame must start from a cleared register.
        run_table(4, 1);

        // T6: back-to-back frames with in_valid held high.
        b6 = qsize(0);
        run_table(6, 0);
        lasts = 0;
        for (int i = b6; i < qsize(0); i++) if (qget(0, i).last) lasts++;
        check("t6_last_count", 32'(lasts), 32'd2);
        if (qsize(0) >= b6 + 8)
            check("t6_no_bubble", qget(0, b6 + 7).cyc - qget(0, b6).cyc, 32'd7);

        // T5: K=7 random frames against a convolution reference.
        rmode[2] = 2'd3;
        base = qsize(2);
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(16, 1);
            xb.delete();
            for (int i = 0; i < len; i++) xb.push_back(1'($urandom_range(1)));
            for (int i = 0; i < len; i++) send_bit(2, xb[i], (i == len - 1));
            for (int i = 0; i < 6; i++) xb.push_back(1'b0);
            for (int j = 0; j < xb.size(); j++) begin
                pg0 = 1'b0;
                pg1 = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (j >= i) begin
                        pg0 ^= G0_7[6-i] & xb[j-i];
                        pg1 ^= G1_7[6-i] & xb[j-i];
                    end
                end
                exp2.push_back({(j == xb.size() - 1), pg0, pg1});
            end
            flen.push_back(xb.size());
        end
        in_valid[2] = 1'b0;
        wait_done(2, base + exp2.size(), 1000);
        check("t5_count", 32'(qsize(2) - base), 32'(exp2.size()));
        idx = 0;
        for (int f = 0; f < flen.size(); f++) begin
            bad = 0;
            first_bad = -1;
            for (int s = 0; s < flen[f]; s++) begin
                if (base + idx < qsize(2)) begin
                    if ({qget(2, base + idx).last, qget(2, base + idx).sym} !== exp2[idx]) begin
                        bad++;
                        if (first_bad < 0) first_bad = s;
                    end
                end else begin
                    bad++;
                end
                idx++;
            end
            $display("t5 frame%0d: %0d symbols, %0d differ (first at %0d)", f, flen[f], bad, first_bad);
            check($sformatf("t5_frame%0d", f), 32'(bad), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
